// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-port arbiter in front of a single-access SDRAM controller.
// Latency: ack/mem_ce one cycle after arbitration, done SLOT_CYCLES cycles after that.
// Backpressure: requests are held until ack; only IDLE and the last SLOT cycle arbitrate.
// Build option: define SDRAM_ARB_ROUND_ROBIN_EN for rotating priority (default fixed 0>1>2).
module sdram_arbiter #(
  parameter int SLOT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [22:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic        p0_ack,
  output logic        p0_done,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [22:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p1_ack,
  output logic        p1_done,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic [22:0] p2_addr,
  input  logic [7:0]  p2_wdata,
  output logic        p2_ack,
  output logic        p2_done,
  output logic [7:0]  rdata,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic {IDLE, SLOT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  cur;
  logic [2:0]  ack_r;
  logic [2:0]  done_r;
  logic [2:0]  req_vec;
  logic        last_slot;
  logic        arb_en;
  logic [1:0]  o0, o1, o2;
  logic [1:0]  win;
  logic        win_vld;
  logic        win_we;
  logic [22:0] win_addr;
  logic [7:0]  win_wdata;

  assign req_vec   = {p2_req, p1_req, p0_req};
  assign last_slot = (state == SLOT) && (cnt == 4'(SLOT_CYCLES - 1));
  // The last slot cycle doubles as an arbitration cycle so grants run back to back.
  assign arb_en    = (state == IDLE) || last_slot;

  assign rdata   = mem_rdata;
  assign p0_ack  = ack_r[0];
  assign p1_ack  = ack_r[1];
  assign p2_ack  = ack_r[2];
  assign p0_done = done_r[0];
  assign p1_done = done_r[1];
  assign p2_done = done_r[2];

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] last;
  // Priority order starts at the port after the last winner.
  assign o0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
  assign o1 = (o0 == 2'd2) ? 2'd0 : o0 + 2'd1;
  assign o2 = (o1 == 2'd2) ? 2'd0 : o1 + 2'd1;
`else
  assign o0 = 2'd0;
  assign o1 = 2'd1;
  assign o2 = 2'd2;
`endif

  // Pick the first requesting port in the current priority order.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    if (req_vec[o0]) begin
      win     = o0;
      win_vld = 1'b1;
    end else if (req_vec[o1]) begin
      win     = o1;
      win_vld = 1'b1;
    end else if (req_vec[o2]) begin
      win     = o2;
      win_vld = 1'b1;
    end
  end

  // Route the winner's access fields toward the memory registers.
  always_comb begin
    win_we    = p0_we;
    win_addr  = p0_addr;
    win_wdata = p0_wdata;
    case (win)
      2'd1: begin
        win_we    = p1_we;
        win_addr  = p1_addr;
        win_wdata = p1_wdata;
      end
      2'd2: begin
        win_we    = p2_we;
        win_addr  = p2_addr;
        win_wdata = p2_wdata;
      end
      default: ;
    endcase
  end

  // Grant FSM: registers the access, pulses ack/done and times the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur       <= '0;
      ack_r     <= '0;
      done_r    <= '0;
      busy      <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last      <= 2'd2;
`endif
    end else begin
      mem_ce <= 1'b0;
      ack_r  <= '0;
      done_r <= last_slot ? (3'b001 << cur) : 3'b000;
      if (arb_en && win_vld) begin
        state     <= SLOT;
        cnt       <= '0;
        cur       <= win;
        busy      <= 1'b1;
        ack_r     <= 3'b001 << win;
        mem_ce    <= 1'b1;
        mem_we    <= win_we;
        mem_addr  <= win_addr;
        mem_wdata <= win_wdata;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        last      <= win;
`endif
      end else if (state == SLOT) begin
        if (last_slot) begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a grant-list reference model.
module tb_sdram_arbiter;
  localparam int S    = 5;
  localparam int NCYC = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [3];
  logic        we    [3];
  logic [22:0] addr  [3];
  logic [7:0]  wdata [3];
  logic [2:0]  ack;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic        mem_ce, mem_we, busy;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int next_arb = 0;
  bit rand_mode = 1'b0;
  bit hold_all  = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  int rr_last = 2;
`endif

  // Expected behaviour indexed by cycle number.
  bit          exp_ce   [NCYC];
  bit [2:0]    exp_ack  [NCYC];
  bit [2:0]    exp_done [NCYC];
  bit          exp_busy [NCYC];
  bit          rd_done  [NCYC];
  bit          rst_at   [NCYC];
  bit          g_we     [NCYC];
  bit [22:0]   g_addr   [NCYC];
  bit [7:0]    g_wdata  [NCYC];
  bit          m_we = 1'b0;
  bit [22:0]   m_addr = '0;
  bit [7:0]    m_wdata = '0;

  sdram_arbiter #(.SLOT_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_ack(ack[0]), .p0_done(done[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_ack(ack[1]), .p1_done(done[1]),
    .p2_req(req[2]), .p2_we(we[2]), .p2_addr(addr[2]), .p2_wdata(wdata[2]),
    .p2_ack(ack[2]), .p2_done(done[2]),
    .rdata(rdata), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs, move requesters, update the model, advance.
  task automatic cycle();
    int win;
    int p;
    if (rst_at[cyc]) begin
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
    end
    if (exp_ce[cyc]) begin
      m_we = g_we[cyc]; m_addr = g_addr[cyc]; m_wdata = g_wdata[cyc];
    end
    chk("mem_ce", 32'(mem_ce), 32'(exp_ce[cyc]));
    chk("ack", 32'(ack), 32'(exp_ack[cyc]));
    chk("done", 32'(done), 32'(exp_done[cyc]));
    chk("busy", 32'(busy), 32'(exp_busy[cyc]));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    if (rd_done[cyc]) chk("rdata", 32'(rdata), 32'(mem_rdata));
    for (int i = 0; i < 3; i++)
      if (exp_ack[cyc][i] && !hold_all) req[i] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i]   = 1'b1;
          we[i]    = 1'($urandom_range(0, 1));
          addr[i]  = 23'($urandom);
          wdata[i] = 8'($urandom);
        end
      end
    end
    mem_rdata = 8'($urandom);
    if (reset) begin
      for (int i = cyc + 1; i <= cyc + S + 2; i++) begin
        exp_ce[i] = 0; exp_ack[i] = 0; exp_done[i] = 0; exp_busy[i] = 0; rd_done[i] = 0;
      end
      rst_at[cyc + 1] = 1'b1;
      next_arb = cyc + 1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_last = 2;
`endif
    end else if (cyc >= next_arb) begin
      win = -1;
      for (int k = 0; k < 3; k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        p = (rr_last + 1 + k) % 3;
`else
        p = k;
`endif
        if (win < 0 && req[p]) win = p;
      end
      if (win >= 0) begin
        exp_ce[cyc + 1]    = 1'b1;
        exp_ack[cyc + 1]   = 3'b001 << win;
        g_we[cyc + 1]      = we[win];
        g_addr[cyc + 1]    = addr[win];
        g_wdata[cyc + 1]   = wdata[win];
        exp_done[cyc + 1 + S] = 3'b001 << win;
        rd_done[cyc + 1 + S]  = !we[win];
        for (int i = 1; i <= S; i++) exp_busy[cyc + i] = 1'b1;
        next_arb = cyc + S;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        rr_last = win;
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1;
    mem_rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    rst_at[1] = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    cycle();
    // Reset state
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    run(2);

    // Single read on port 1
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 23'h000123; wdata[1] = 8'h00;
    cycle();
    chk("rd_ack", 32'(ack), 32'b010);
    chk("rd_mem_ce", 32'(mem_ce), 32'd1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h000123);
    run(5);
    mem_rdata = 8'h5C;
    chk("rd_done", 32'(done), 32'b010);
    chk("rd_rdata", 32'(rdata), 32'h5C);

    // Single write on port 2
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 23'h7FFFFF; wdata[2] = 8'hA5;
    cycle();
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    chk("wr_mem_addr", 32'(mem_addr), 32'h7FFFFF);
    run(5);
    chk("wr_done", 32'(done), 32'b100);

    // All ports requesting continuously
    hold_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1; we[i] = i[0]; addr[i] = 23'(i * 16 + 5); wdata[i] = 8'(i + 1);
    end
    cycle();
    chk("cont_first_ack", 32'(ack), 32'b001);
    run(5);
    chk("cont_second_ce", 32'(mem_ce), 32'd1);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    chk("cont_second_ack", 32'(ack), 32'b010);
`else
    chk("cont_second_ack", 32'(ack), 32'b001);
`endif
    run(20);
    hold_all = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    run(8);

    // Reset three cycles into a read
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 23'h2A5A5; wdata[0] = 8'h3C;
    run(3);
    reset = 1'b1;
    cycle();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    run(8);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 23'h00F00F;
    cycle();
    chk("post_rst_ack", 32'(ack), 32'b100);
    run(7);

    // Withdrawn request during a slot
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 23'h11; wdata[0] = 8'h22;
    run(2);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 23'h33;
    cycle();
    req[1] = 1'b0;
    run(12);

    // Random traffic
    rand_mode = 1'b1;
    run(1500);
    rand_mode = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
